// File: rtl/jump_unit.sv
// jump_unit: control-transfer stage for an RV32/RV64 integer core.
//   Owns the architectural PC, resolves JAL/JALR targets, flags misaligned
//   jump targets, accepts external redirects and registers its result behind
//   a valid/ready handshake. Also keeps a saturating count of taken jumps.
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready         instruction handshake from fetch
//   in_instr, in_rs1_val      instruction at pc and its rs1 operand (JALR)
//   redirect_valid/_pc        external PC override, wins over accept
//   pc                        current architectural PC
//   out_valid/out_ready       result handshake towards writeback/redirect
//   out_pc_next               next PC, or faulting target when out_exc=1
//   out_rd_addr/data/we       link register write
//   out_jump, out_exc         taken jump / instruction-address-misaligned
//   jump_count                saturating count of taken jumps
module jump_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              IALIGN   = 32,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_rs1_val,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc_next,
    output logic [4:0]       out_rd_addr,
    output logic [XLEN-1:0]  out_rd_data,
    output logic             out_rd_we,
    output logic             out_jump,
    output logic             out_exc,
    output logic [CNT_W-1:0] jump_count
);

    localparam logic [6:0]       OP_JAL  = 7'b1101111;
    localparam logic [6:0]       OP_JALR = 7'b1100111;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [XLEN-1:0]  pc_r;
    logic             out_valid_r;
    logic [XLEN-1:0]  out_pc_next_r;
    logic [4:0]       out_rd_addr_r;
    logic [XLEN-1:0]  out_rd_data_r;
    logic             out_rd_we_r;
    logic             out_jump_r;
    logic             out_exc_r;
    logic [CNT_W-1:0] jump_count_r;

    logic             is_jal_s;
    logic             is_jalr_s;
    logic             is_jump_s;
    logic [XLEN-1:0]  j_imm_s;
    logic [XLEN-1:0]  i_imm_s;
    logic [XLEN-1:0]  link_s;
    logic [XLEN-1:0]  target_s;
    logic             exc_s;
    logic             take_s;
    logic             rd_we_s;
    logic             accept_s;

    // Handshake: a slot is free when empty or when the consumer drains it now.
    always_comb begin
        in_ready = !out_valid_r || out_ready;
        accept_s = in_valid && in_ready && !redirect_valid;
    end

    // Decode and target resolution against the current architectural PC.
    always_comb begin
        is_jal_s  = (in_instr[6:0] == OP_JAL);
        is_jalr_s = (in_instr[6:0] == OP_JALR) && (in_instr[14:12] == 3'b000);
        is_jump_s = is_jal_s || is_jalr_s;
        j_imm_s   = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
        i_imm_s   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        link_s    = pc_r + {{(XLEN-3){1'b0}}, 3'd4};
        target_s  = link_s;
        if (is_jal_s) begin
            target_s = pc_r + j_imm_s;
        end else if (is_jalr_s) begin
            // JALR clears bit 0 of the computed address.
            target_s = (in_rs1_val + i_imm_s) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            target_s = link_s;
        end
        // Only jumps can fault; with compressed support halfword targets are legal.
        if (IALIGN == 32) begin
            exc_s = is_jump_s && target_s[1];
        end else begin
            exc_s = 1'b0;
        end
        take_s  = is_jump_s && !exc_s;
        rd_we_s = take_s && (in_instr[11:7] != 5'd0);
    end

    // PC, result register and taken-jump counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            out_valid_r   <= 1'b0;
            out_pc_next_r <= {XLEN{1'b0}};
            out_rd_addr_r <= 5'd0;
            out_rd_data_r <= {XLEN{1'b0}};
            out_rd_we_r   <= 1'b0;
            out_jump_r    <= 1'b0;
            out_exc_r     <= 1'b0;
            jump_count_r  <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            // A redirect flushes any pending result and blocks accept this cycle.
            pc_r        <= redirect_pc;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r   <= 1'b1;
            out_pc_next_r <= target_s;
            out_rd_addr_r <= in_instr[11:7];
            out_rd_data_r <= link_s;
            out_rd_we_r   <= rd_we_s;
            out_jump_r    <= take_s;
            out_exc_r     <= exc_s;
            if (!exc_s) begin
                pc_r <= target_s;
            end else begin
                pc_r <= pc_r;
            end
            if (take_s && (jump_count_r != CNT_MAX)) begin
                jump_count_r <= jump_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                jump_count_r <= jump_count_r;
            end
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign pc          = pc_r;
    assign out_valid   = out_valid_r;
    assign out_pc_next = out_pc_next_r;
    assign out_rd_addr = out_rd_addr_r;
    assign out_rd_data = out_rd_data_r;
    assign out_rd_we   = out_rd_we_r;
    assign out_jump    = out_jump_r;
    assign out_exc     = out_exc_r;
    assign jump_count  = jump_count_r;

endmodule

// File: doc/jump_unit.md
Name: jump_unit

Overview:
Parameterised sequential control-transfer stage for the RV32/RV64 integer core. It generalises single-instruction JAL decoding with the following additions:
- Owns the architectural PC register.
- Handles JAL and JALR.
- Detects misaligned jump targets.
- Accepts external redirects.
- Registers its result behind a valid/ready handshake.
- Counts taken jumps.

It sits between fetch (instruction in) and writeback/fetch-redirect (results out).

Parameters:
XLEN, 32, datapath and PC width (32 or 64)
RESET_PC, 0, PC value loaded on reset
IALIGN, 32, instruction alignment in bits (32 or 16; 16 permits compressed targets)
CNT_W, 16, width of taken-jump counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  instruction present
in_ready  output  1  stage can accept instruction
in_instr  input  32  instruction at current pc
in_rs1_val  input  XLEN  rs1 operand value (used by JALR)
redirect_valid  input  1  external PC override (trap/branch flush)
redirect_pc  input  XLEN  override target
pc  output  XLEN  current architectural PC (pc_q)
out_valid  output  1  result register holds valid result
out_ready  input  1  consumer takes result
out_pc_next  output  XLEN  next PC, or faulting target when out_exc=1
out_rd_addr  output  5  link register index
out_rd_data  output  XLEN  link value (pc+4)
out_rd_we  output  1  link write enable
out_jump  output  1  result is a taken jump
out_exc  output  1  instruction-address-misaligned exception
jump_count  output  CNT_W  saturating count of taken jumps

Behaviour:
- Reset (async, immediate):
  - pc_q=RESET_PC, out_valid=0, jump_count=0.
  - All out_* data fields = 0.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept = in_valid && in_ready && !redirect_valid.
  - Result is visible on out_* one cycle after accept (latency 1).
  - out_* held stable while out_valid && !out_ready.
  - out_valid drops the cycle after out_ready unless a new accept occurs in the same cycle, in which case the new result replaces the old one back-to-back (full throughput).
- Decode, using pc_q at accept:
  - JAL (opcode 1101111): target = pc_q + sext(J-imm, 21→XLEN), where J-imm = {i[31],i[19:12],i[20],i[30:21],0}.
  - JALR (opcode 1100111, funct3 000): target = (in_rs1_val + sext(i[31:20])) with bit0 cleared.
  - Any other instruction: target = pc_q+4, out_jump=0, out_rd_we=0, out_exc=0.
- Arithmetic:
  - All sums are modulo 2^XLEN (wrap-around; no overflow flag).
  - Link value = pc_q+4, also modulo 2^XLEN.
- Misalignment:
  - With IALIGN=32, target[1]=1 → exception. With IALIGN=16, no exception.
  - On exception: out_exc=1, out_jump=0, out_rd_we=0, out_pc_next=target, pc_q unchanged, jump_count unchanged.
- Link write: out_rd_we=1 only for a non-excepting JAL/JALR with rd≠0. out_rd_addr = i[11:7] always.
- PC update on accept:
  - Non-excepting: pc_q ← out_pc_next value (target or pc_q+4).
  - Excepting: pc_q held.
- jump_count: increments on accept of a non-excepting JAL/JALR; saturates at 2^CNT_W−1 (no wrap).
- Redirect:
  - redirect_valid has priority over accept.
  - Effect: pc_q ← redirect_pc, out_valid ← 0 (pending result discarded), no accept that cycle, counter unchanged.
- Reset asserted mid-handshake: pending result lost; no out_valid pulse after release until a new accept.

Test Plan:
1. Reset: RESET_PC=0x100, release rst, in_valid=0 → pc=0x100, out_valid=0, jump_count=0.
2. JAL forward: pc=0x100, instr=0x008000EF (jal x1,+8), out_ready=1 → next cycle out_valid=1, out_pc_next=0x108, out_rd_addr=1, out_rd_data=0x104, out_rd_we=1, out_jump=1; pc=0x108; jump_count=1.
3. JALR with bit0 clear and rd=0: in_rs1_val=0x2001, instr=jalr x0,4(rs1) → out_pc_next=0x2004, out_rd_we=0, out_jump=1.
4. Misaligned: in_rs1_val=0x2002, jalr x1,0(rs1), IALIGN=32 → out_exc=1, out_pc_next=0x2002, out_rd_we=0, pc unchanged, jump_count unchanged. Rerun with IALIGN=16 → out_exc=0, pc=0x2002.
5. Backpressure and redirect:
   - Hold out_ready=0 with a result pending → in_ready=0, out_* stable for 3 cycles.
   - Then assert redirect_valid with redirect_pc=0x400 together with in_valid → out_valid=0, pc=0x400, no accept.
6. Wrap and saturation:
   - pc=0xFFFFFFFC, non-jump instruction → pc=0x00000000.
   - CNT_W=2, 5 accepted jumps → jump_count=3.
